// File: rtl/rtc_pkg.sv
// Shared widths, constants and types for the PTP real-time clock.
package rtc_pkg;

    localparam int unsigned NS_PER_SEC = 1_000_000_000;

    localparam int NS_W      = 30;  // integer-ns field
    localparam int NSF_OUT_W = 8;   // exported fractional-ns bits
    localparam int FRAC_W    = 32;  // internal fractional-ns bits
    localparam int SEC_W     = 48;
    localparam int PER_W     = 40;  // {ns[7:0], nsf[31:0]}
    localparam int ADJ_W     = 32;  // adjust window length in cycles

    localparam int ACC_W     = NS_W + FRAC_W;      // 62
    localparam int TIME_NS_W = NS_W + NSF_OUT_W;   // 38

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [SEC_W-1:0] sec_t;

    // One second expressed in accumulator units (ns << FRAC_W).
    localparam acc_t SEC_IN_ACC = acc_t'(NS_PER_SEC) << FRAC_W;

    // True when the integer-ns part of an accumulator value has reached one second.
    function automatic logic ns_overflow(input acc_t value);
        return value[ACC_W-1:FRAC_W] >= NS_W'(NS_PER_SEC);
    endfunction

endpackage

// File: rtl/rtc_adj_ctrl.sv
// Period / period-adjust registers, adjust-window counter and increment select.
module rtc_adj_ctrl
    import rtc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             time_ld,
    input  logic             period_ld,
    input  logic [PER_W-1:0] period_in,
    input  logic             adj_ld,
    input  logic [ADJ_W-1:0] adj_len,
    input  logic [PER_W-1:0] period_adj_in,
    output logic [PER_W-1:0] inc,
    output logic             adj_done
);

    logic [PER_W-1:0] period;
    logic [PER_W-1:0] period_adj;
    logic [ADJ_W-1:0] adj_cnt;

    // Period registers and adjust window: a new load restarts the window, a time-load cycle pauses it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period     <= '0;
            period_adj <= '0;
            adj_cnt    <= '0;
            adj_done   <= 1'b1;
        end else if (clr) begin
            period     <= '0;
            period_adj <= '0;
            adj_cnt    <= '0;
            adj_done   <= 1'b1;
        end else begin
            if (period_ld) begin
                period <= period_in;
            end
            if (adj_ld) begin
                period_adj <= period_adj_in;
                adj_cnt    <= adj_len;
                adj_done   <= (adj_len == '0);
            end else if (!time_ld && adj_cnt != '0) begin
                adj_cnt  <= adj_cnt - ADJ_W'(1);
                adj_done <= (adj_cnt == ADJ_W'(1));
            end
        end
    end

    // Increment used this cycle comes from the registered window state, so a load cycle uses the old selection.
    assign inc = (adj_cnt != '0) ? period_adj : period;

endmodule

// File: rtl/rtc_core.sv
// PTP real-time clock: fractional-ns accumulator, one-second wrap and seconds counter.
module rtc_core
    import rtc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rtc_rst_in,
    input  logic                 time_ld_in,
    input  logic [TIME_NS_W-1:0] time_reg_ns_in,
    input  logic [SEC_W-1:0]     time_reg_sec_in,
    input  logic                 period_ld_in,
    input  logic [PER_W-1:0]     period_in,
    input  logic                 adj_ld_in,
    input  logic [ADJ_W-1:0]     adj_ld_data_in,
    input  logic [PER_W-1:0]     period_adj_in,
    output logic                 adj_ld_done_out,
    output logic [TIME_NS_W-1:0] time_reg_ns_out,
    output logic [SEC_W-1:0]     time_reg_sec_out,
    output logic                 pps_out
);

    acc_t             acc;
    acc_t             sum;
    acc_t             sum_wrapped;
    logic             wrap;
    sec_t             sec;
    logic             pps;
    logic [PER_W-1:0] inc;

    rtc_adj_ctrl u_adj_ctrl (
        .clk           (clk),
        .rst           (rst),
        .clr           (rtc_rst_in),
        .time_ld       (time_ld_in),
        .period_ld     (period_ld_in),
        .period_in     (period_in),
        .adj_ld        (adj_ld_in),
        .adj_len       (adj_ld_data_in),
        .period_adj_in (period_adj_in),
        .inc           (inc),
        .adj_done      (adj_ld_done_out)
    );

    // Next accumulator value and single wrap test; at most one second is removed per cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        sum         = acc + acc_t'(inc);
        wrap        = ns_overflow(sum);
        sum_wrapped = sum - SEC_IN_ACC;
    end

    // Time state: soft reset beats time load, time load beats the increment.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (!rst) begin
            acc <= '0;
            sec <= '0;
            pps <= 1'b0;
        end else if (rtc_rst_in) begin
            acc <= '0;
            sec <= '0;
            pps <= 1'b0;
        end else if (time_ld_in) begin
            acc <= {time_reg_ns_in, {(FRAC_W-NSF_OUT_W){1'b0}}};
            sec <= time_reg_sec_in;
            pps <= 1'b0;
        end else if (wrap) begin
            acc <= sum_wrapped;
            sec <= sec + sec_t'(1);
            pps <= 1'b1;
        end else begin
            acc <= sum;
            pps <= 1'b0;
        end
    end

    assign time_reg_ns_out  = acc[ACC_W-1:ACC_W-TIME_NS_W];
    assign time_reg_sec_out = sec;
    assign pps_out          = pps;

endmodule

// File: tb/tb_rtc_core.sv
// Scoreboarded bench for rtc_core: directed scenarios plus randomized traffic against a plain-arithmetic model.
module tb_rtc_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rtc_rst_in;
    logic        time_ld_in;
    logic [37:0] time_reg_ns_in;
    logic [47:0] time_reg_sec_in;
    logic        period_ld_in;
    logic [39:0] period_in;
    logic        adj_ld_in;
    logic [31:0] adj_ld_data_in;
    logic [39:0] period_adj_in;
    logic        adj_ld_done_out;
    logic [37:0] time_reg_ns_out;
    logic [47:0] time_reg_sec_out;
    logic        pps_out;

    always #5 clk = ~clk;

    rtc_core dut (
        .clk              (clk),
        .rst              (rst),
        .rtc_rst_in       (rtc_rst_in),
        .time_ld_in       (time_ld_in),
        .time_reg_ns_in   (time_reg_ns_in),
        .time_reg_sec_in  (time_reg_sec_in),
        .period_ld_in     (period_ld_in),
        .period_in        (period_in),
        .adj_ld_in        (adj_ld_in),
        .adj_ld_data_in   (adj_ld_data_in),
        .period_adj_in    (period_adj_in),
        .adj_ld_done_out  (adj_ld_done_out),
        .time_reg_ns_out  (time_reg_ns_out),
        .time_reg_sec_out (time_reg_sec_out),
        .pps_out          (pps_out)
    );

    typedef struct {
        logic [37:0] ns;
        logic [47:0] sec;
        logic        pps;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time kept as one number in units of 2^-32 ns; seconds as a plain counter.
    localparam longint unsigned ONE_SEC  = 64'd1_000_000_000 << 32;
    localparam longint unsigned MOD_ACC  = 64'h4000_0000_0000_0000;
    localparam longint unsigned MOD_SEC  = 64'h0001_0000_0000_0000;

    longint unsigned m_time;
    longint unsigned m_sec;
    longint unsigned m_period;
    longint unsigned m_adj;
    int unsigned     m_win;
    bit              m_pps;

    task automatic model_clear();
        m_time = 0; m_sec = 0; m_period = 0; m_adj = 0; m_win = 0; m_pps = 0;
    endtask

    task automatic model_step();
        longint unsigned step, t;
        bit in_window;
        in_window = (m_win != 0);
        if (rtc_rst_in) begin
            model_clear();
        end else begin
            step = in_window ? m_adj : m_period;
            if (time_ld_in) begin
                m_time = longint'(time_reg_ns_in) << 24;
                m_sec  = time_reg_sec_in;
                m_pps  = 0;
            end else begin
                t = (m_time + step) % MOD_ACC;
                m_pps = (t >= ONE_SEC);
                if (m_pps) begin
                    t     = t - ONE_SEC;
                    m_sec = (m_sec + 1) % MOD_SEC;
                end
                m_time = t;
                if (in_window) m_win--;
            end
            if (period_ld_in) m_period = period_in;
            if (adj_ld_in) begin
                m_adj = period_adj_in;
                m_win = adj_ld_data_in;
            end
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        exp_t e;
        model_step();
        e.ns   = 38'(m_time >> 24);
        e.sec  = 48'(m_sec);
        e.pps  = m_pps;
        e.done = (m_win == 0);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        rtc_rst_in   = 1'b0;
        time_ld_in   = 1'b0;
        period_ld_in = 1'b0;
        adj_ld_in    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_time(input logic [37:0] ns, input logic [47:0] sec);
        time_ld_in = 1'b1; time_reg_ns_in = ns; time_reg_sec_in = sec;
    endtask

    task automatic load_adj(input logic [39:0] per, input logic [31:0] len);
        adj_ld_in = 1'b1; period_adj_in = per; adj_ld_data_in = len;
    endtask

    // ---------------- monitor ----------------
    // Every cycle the DUT presents a timestamp; compare it against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("sb_ns",   64'(time_reg_ns_out),  64'(mon_e.ns));
            check("sb_sec",  64'(time_reg_sec_out), 64'(mon_e.sec));
            check("sb_pps",  64'(pps_out),          64'(mon_e.pps));
            check("sb_done", 64'(adj_ld_done_out),  64'(mon_e.done));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d checks", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        rtc_rst_in = 1'b0; time_ld_in = 1'b0; period_ld_in = 1'b0; adj_ld_in = 1'b0;
        time_reg_ns_in = '0; time_reg_sec_in = '0; period_in = '0;
        adj_ld_data_in = '0; period_adj_in = '0;
        model_clear();
        #12;
        check("rst_ns",   64'(time_reg_ns_out),  64'd0);
        check("rst_sec",  64'(time_reg_sec_out), 64'd0);
        check("rst_pps",  64'(pps_out),          64'd0);
        check("rst_done", 64'(adj_ld_done_out),  64'd1);
        rst = 1'b1;
        @(negedge clk);

        // 8 ns period, ten increments -> 80 ns
        period_ld_in = 1'b1; period_in = 40'h08_0000_0000;
        tick();
        run(10);
        check("p8_ns",   64'(time_reg_ns_out),  64'h5000);
        check("p8_sec",  64'(time_reg_sec_out), 64'd0);
        check("p8_done", 64'(adj_ld_done_out),  64'd1);

        // second wrap with pps pulse
        load_time(38'(64'd999_999_992 << 8), 48'd5);
        tick();
        check("ld_ns",  64'(time_reg_ns_out),  64'd999_999_992 << 8);
        check("ld_sec", 64'(time_reg_sec_out), 64'd5);
        tick();
        check("wrap_ns",  64'(time_reg_ns_out),  64'd0);
        check("wrap_sec", 64'(time_reg_sec_out), 64'd6);
        check("wrap_pps", 64'(pps_out),          64'd1);
        tick();
        check("pps_once", 64'(pps_out),          64'd0);
        check("post_ns",  64'(time_reg_ns_out),  64'h800);

        // half-ns period
        load_time('0, '0); period_ld_in = 1'b1; period_in = 40'h00_8000_0000;
        tick();
        run(4);
        check("half4_ns", 64'(time_reg_ns_out), 64'h200);
        load_time('0, '0);
        tick();
        run(3);
        check("half3_ns", 64'(time_reg_ns_out), 64'h180);

        // adjust window: 8 ns base, 9 ns for 3 cycles
        load_time('0, '0); period_ld_in = 1'b1; period_in = 40'h08_0000_0000;
        tick();
        load_adj(40'h09_0000_0000, 32'd3);
        tick();
        check("adj_load_ns", 64'(time_reg_ns_out), 64'd8 << 8);
        check("adj_load_done", 64'(adj_ld_done_out), 64'd0);
        tick();
        check("adj_c1_done", 64'(adj_ld_done_out), 64'd0);
        tick();
        check("adj_c2_done", 64'(adj_ld_done_out), 64'd0);
        tick();
        check("adj_end_ns",   64'(time_reg_ns_out), 64'd35 << 8);
        check("adj_end_done", 64'(adj_ld_done_out), 64'd1);
        tick();
        check("adj_after_ns", 64'(time_reg_ns_out), 64'd43 << 8);

        // soft reset beats a simultaneous time load mid-window
        load_adj(40'h09_0000_0000, 32'd5);
        tick();
        tick();
        rtc_rst_in = 1'b1; load_time(38'd123, 48'd77);
        tick();
        check("srst_ns",   64'(time_reg_ns_out),  64'd0);
        check("srst_sec",  64'(time_reg_sec_out), 64'd0);
        check("srst_done", 64'(adj_ld_done_out),  64'd1);
        tick();
        check("srst_hold_ns", 64'(time_reg_ns_out), 64'd0);

        // zero-length window, then restart mid-window
        period_ld_in = 1'b1; period_in = 40'h08_0000_0000;
        tick();
        load_adj(40'h03_0000_0000, 32'd0);
        tick();
        check("zero_len_done", 64'(adj_ld_done_out), 64'd1);
        run(2);
        load_adj(40'h03_0000_0000, 32'd4);
        tick();
        run(2);
        load_adj(40'h05_0000_0000, 32'd6);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("restart_busy", 64'(adj_ld_done_out), 64'd0);
        end
        tick();
        check("restart_done", 64'(adj_ld_done_out), 64'd1);

        // zero period: time holds outside the window, window still counts
        period_ld_in = 1'b1; period_in = '0; load_time('0, 48'd3);
        tick();
        load_adj(40'h04_0000_0000, 32'd2);
        tick();
        run(3);
        check("p0_ns",   64'(time_reg_ns_out), 64'd8 << 8);
        check("p0_done", 64'(adj_ld_done_out), 64'd1);

        // async reset in the middle of a window
        period_ld_in = 1'b1; period_in = 40'h08_0000_0000;
        tick();
        load_adj(40'h0A_0000_0000, 32'd10);
        run(3);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_ns",   64'(time_reg_ns_out),  64'd0);
        check("arst_sec",  64'(time_reg_sec_out), 64'd0);
        check("arst_done", 64'(adj_ld_done_out),  64'd1);
        model_clear();
        #1;
        rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rtc_rst_in = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 2))
                    0: time_reg_ns_in = {30'(1_000_000_000 - $urandom_range(1, 300)), 8'($urandom())};
                    1: time_reg_ns_in = {30'($urandom_range(1_073_741_823, 1_000_000_000)), 8'($urandom())};
                    default: time_reg_ns_in = {30'($urandom_range(999_999_999, 0)), 8'($urandom())};
                endcase
                time_reg_sec_in = ($urandom_range(0, 2) == 0) ? 48'hFFFF_FFFF_FFFF
                                                               : {16'($urandom()), 32'($urandom())};
                time_ld_in = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                period_ld_in = 1'b1;
                period_in    = {8'($urandom_range(0, 40)), 32'($urandom())};
            end
            if ($urandom_range(0, 14) == 0) begin
                load_adj({8'($urandom_range(0, 40)), 32'($urandom())}, 32'($urandom_range(0, 12)));
            end
            tick();
        end

        @(negedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
